fpmul_out_buf: RTL and testbench
================================

Name: fpmul_out_buf

Overview:
Output buffer placed directly downstream of the pipelined FP multiplier. It captures each result word when the valid delay line marks it valid, tags it with IEEE-754 special-value flags and holds it in a small FIFO. It then presents the results to a consumer through a valid/ready handshake. The multiplier cannot stall, so the buffer never back-pressures it: on overflow it drops the word and records the event.

Parameters:
DW, 32, data word width (IEEE-754 single precision; the flag logic is fixed to the 32-bit layout)
DEPTH, 8, FIFO entries; power of two, >= 2
AW, 3, pointer width = log2(DEPTH)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, synchronous, active-high
din  in  DW  multiplier result (FP_Z)
vin  in  1  din valid, from the latency delay line
dout  out  DW  head-of-FIFO word; 0 when empty
dout_flags  out  3  {is_nan, is_inf, is_zero} of dout; 0 when empty
vout  out  1  dout valid (FIFO not empty)
rdy  in  1  consumer ready
count  out  AW+1  current occupancy, 0..DEPTH
ovf  out  1  sticky overflow flag
ovf_clr  in  1  synchronous clear of ovf and drop_cnt
drop_cnt  out  8  number of dropped words, saturates at 255

Behaviour:
- Clock is `clk`. Reset `rst` is synchronous and active-high, sampled on the rising edge of `clk`. It has priority over every other input.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, vout=0, dout=0, dout_flags=0, ovf=0, drop_cnt=0. Memory contents are don't-care.
- A reset asserted mid-operation discards all stored entries at that edge. A vin seen in the same cycle as rst is ignored.
- Flags are computed from din at write time and stored alongside the data (entry width DW+3):
  - exp=din[30:23], man=din[22:0].
  - is_nan = (exp==8'hFF) && (man!=0).
  - is_inf = (exp==8'hFF) && (man==0).
  - is_zero = (exp==0) && (man==0). The sign bit is ignored, so -0 is also zero.
  - Denormals (exp==0, man!=0) set no flag.
- Push: push_req = vin. Pop: pop = vout && rdy.
- Pop timing: the FIFO is first-word-fall-through. dout/dout_flags always show mem[rd_ptr] while count>0.
- Push timing: a push at edge N makes the word visible, with vout=1, from edge N onward, i.e. in cycle N+1. There is no write-to-read bypass within the same cycle.
- If empty: pop is impossible because vout=0. A push is always accepted.
- If full (count==DEPTH) with a simultaneous pop: the push is accepted, the pointers both advance and count is unchanged.
- If full without a pop: the word is dropped. ovf is set to 1 and drop_cnt increments, saturating at 255. No pointer moves.
- Pointers increment modulo DEPTH, wrapping from DEPTH-1 to 0. count is updated as +1 on push-only, -1 on pop-only, and unchanged for both or neither.
- ovf_clr: at the next edge it clears ovf and drop_cnt. If a drop occurs in the same cycle, the drop wins: ovf=1 and drop_cnt=1.
- rdy asserted while vout=0 has no effect. dout must stay stable while vout=1 and rdy=0.
- No combinational path from din/vin to any output. rdy affects outputs only after the next edge.

Test Plan:
- Reset, then single push din=0x40400000 (3.0) at edge N -> vout=1 from cycle N+1, dout=0x40400000, flags=000, count=1. Pop with rdy=1 -> vout=0, dout=0, count=0.
- Flag classification: push 0x7FC00000, 0x7F800000, 0x80000000, 0x00000001, 0xFF800000 -> popped flags in order 100, 010, 001, 000, 010.
- Fill with rdy=0: push 8 words 0x3F800000+i -> count=8. A 9th push -> dropped, ovf=1, drop_cnt=1. Draining returns exactly 0x3F800000..0x3F800007 in order.
- Full plus simultaneous push/pop: count=8 and rdy=1 with vin=1 (din=0xDEADBEEF) -> ovf stays 0, count stays 8, and 0xDEADBEEF is the last word out after 8 pops. Check wrap-around by running 20 such cycles against a reference queue.
- ovf_clr with concurrent drop: full, rdy=0, vin=1 and ovf_clr=1 in the same cycle -> ovf=1, drop_cnt=1. ovf_clr alone on the next cycle -> ovf=0, drop_cnt=0. Continuous dropping for 300 cycles -> drop_cnt holds at 255.
- Mid-stream reset: with count=5, assert rst together with vin=1 -> next cycle count=0, vout=0, dout=0, ovf=0. The next push is then the only word output.

Source files
------------

// File: rtl/fpmul_out_buf.sv
// Purpose : FWFT result buffer behind the FP multiplier. Tags each word with NaN/Inf/zero flags and drops it on overflow.
// Latency : a word pushed at edge N is visible on dout/vout in cycle N+1; nothing passes straight from din/vin to an output.
// Backpres: the multiplier is never stalled. The consumer uses vout/rdy. When full with no pop, the word is dropped and counted.
// Ports   : clk, rst (sync, active-high) | din, vin : multiplier result and valid
//           dout, dout_flags {nan,inf,zero}, vout, rdy : consumer handshake; dout and flags read 0 when empty
//           count : occupancy | ovf, drop_cnt, ovf_clr : sticky overflow, saturating drop counter, and their clear
module fpmul_out_buf #(
  parameter int DW    = 32,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  input  logic          vin,
  output logic [DW-1:0] dout,
  output logic [2:0]    dout_flags,
  output logic          vout,
  input  logic          rdy,
  output logic [AW:0]   count,
  output logic          ovf,
  input  logic          ovf_clr,
  output logic [7:0]    drop_cnt
);

  localparam int EW = DW + 3;

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;

  logic [7:0]  din_exp;
  logic [22:0] din_man;
  logic [2:0]  din_flags;
  logic        full;
  logic        pop;
  logic        push;
  logic        drop;

  // The flag layout assumes IEEE-754 single precision. The sign bit is
  // ignored, so -0 is also reported as zero.
  assign din_exp = din[30:23];
  assign din_man = din[22:0];

  always_comb begin
    din_flags    = 3'b000;
    din_flags[2] = (din_exp == 8'hFF) && (din_man != 23'd0);
    din_flags[1] = (din_exp == 8'hFF) && (din_man == 23'd0);
    din_flags[0] = (din_exp == 8'h00) && (din_man == 23'd0);
  end

  assign full = (cnt == (AW+1)'(DEPTH));
  assign vout = (cnt != '0);
  assign pop  = vout && rdy;
  // A pop in the same cycle frees a slot, so a full buffer still accepts the word.
  assign push = vin && (!full || pop);
  assign drop = vin && full && !pop;

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem[wr_ptr] <= {din_flags, din};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // If a drop and a clear happen together, the drop wins. The counter then
  // restarts at 1 instead of being cleared.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf      <= 1'b0;
      drop_cnt <= 8'd0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (ovf_clr)
        drop_cnt <= 8'd1;
      else if (drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 8'd1;
    end else if (ovf_clr) begin
      ovf      <= 1'b0;
      drop_cnt <= 8'd0;
    end
  end

  assign count      = cnt;
  assign dout       = vout ? mem[rd_ptr][DW-1:0]  : '0;
  assign dout_flags = vout ? mem[rd_ptr][EW-1:DW] : 3'b000;

endmodule

// File: tb/tb_fpmul_out_buf.sv
// Purpose : self-checking bench for fpmul_out_buf, using a reference queue as the scoreboard.
// Latency : inputs are driven 1 time unit after posedge; state is compared on every negedge.
// Backpres: rdy is driven by the stimulus sequence.
module tb_fpmul_out_buf;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] din;
  logic        vin;
  logic [31:0] dout;
  logic [2:0]  dout_flags;
  logic        vout;
  logic        rdy;
  logic [3:0]  count;
  logic        ovf;
  logic        ovf_clr;
  logic [7:0]  drop_cnt;

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;

  logic [34:0] ref_q[$];
  logic [34:0] pop_log[$];
  logic        m_ovf = 1'b0;
  int          m_drop = 0;

  fpmul_out_buf #(.DW(32), .DEPTH(DEPTH), .AW(3)) dut (
    .clk(clk), .rst(rst), .din(din), .vin(vin), .dout(dout),
    .dout_flags(dout_flags), .vout(vout), .rdy(rdy), .count(count),
    .ovf(ovf), .ovf_clr(ovf_clr), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [2:0] fp_class(input logic [31:0] w);
    logic nan, inf, zero;
    nan  = (w[30:23] == 8'hFF) && (w[22:0] != 0);
    inf  = (w[30:23] == 8'hFF) && (w[22:0] == 0);
    zero = (w[30:0] == 31'd0);
    return {nan, inf, zero};
  endfunction

  // Check the DUT state against the model, then advance the model by the
  // inputs that the next posedge will sample.
  always @(negedge clk) begin
    if (mon_en) begin
      bit   m_pop;
      bit   m_full;
      check("vout", vout, (ref_q.size() != 0));
      check("count", count, ref_q.size());
      check("ovf", ovf, m_ovf);
      check("drop_cnt", drop_cnt, m_drop);
      if (ref_q.size() != 0) begin
        check("dout", dout, ref_q[0][31:0]);
        check("flags", dout_flags, ref_q[0][34:32]);
      end else begin
        check("dout_empty", dout, 0);
        check("flags_empty", dout_flags, 0);
      end
      if (rst) begin
        ref_q.delete();
        m_ovf  = 1'b0;
        m_drop = 0;
      end else begin
        m_full = (ref_q.size() == DEPTH);
        m_pop  = rdy && (ref_q.size() != 0);
        if (m_pop) begin
          pop_log.push_back({dout_flags, dout});
          void'(ref_q.pop_front());
        end
        if (vin && m_full && !m_pop) begin
          m_ovf  = 1'b1;
          m_drop = ovf_clr ? 1 : ((m_drop < 255) ? m_drop + 1 : 255);
        end else begin
          if (vin)
            ref_q.push_back({fp_class(din), din});
          if (ovf_clr) begin
            m_ovf  = 1'b0;
            m_drop = 0;
          end
        end
      end
    end
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push_word(input logic [31:0] w);
    vin = 1'b1;
    din = w;
    cyc();
    vin = 1'b0;
  endtask

  task automatic drain();
    rdy = 1'b1;
    cyc(DEPTH + 1);
    rdy = 1'b0;
  endtask

  initial begin
    logic [31:0] cls_w [5];
    logic [2:0]  cls_f [5];
    cls_w[0] = 32'h7FC00000; cls_f[0] = 3'b100;
    cls_w[1] = 32'h7F800000; cls_f[1] = 3'b010;
    cls_w[2] = 32'h80000000; cls_f[2] = 3'b001;
    cls_w[3] = 32'h00000001; cls_f[3] = 3'b000;
    cls_w[4] = 32'hFF800000; cls_f[4] = 3'b010;

    rst = 1'b1; vin = 1'b0; din = '0; rdy = 1'b0; ovf_clr = 1'b0;
    cyc(2);
    rst = 1'b0;
    mon_en = 1'b1;
    check("rst_count", count, 0);
    check("rst_vout", vout, 0);
    check("rst_dout", dout, 0);

    // A single push becomes visible the cycle after its edge. Popping it
    // leaves the buffer empty.
    push_word(32'h40400000);
    check("t1_vout", vout, 1);
    check("t1_dout", dout, 32'h40400000);
    check("t1_flags", dout_flags, 3'b000);
    check("t1_count", count, 1);
    rdy = 1'b1; cyc(); rdy = 1'b0;
    check("t1_pop_vout", vout, 0);
    check("t1_pop_dout", dout, 0);

    // Flag classification
    for (int i = 0; i < 5; i++) push_word(cls_w[i]);
    pop_log.delete();
    drain();
    check("cls_n", pop_log.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < pop_log.size()) check($sformatf("cls_flags%0d", i), pop_log[i][34:32], cls_f[i]);

    // Fill the buffer, overflow it, then drain it in order.
    for (int i = 0; i < 8; i++) push_word(32'h3F800000 + i);
    check("fill_count", count, 8);
    push_word(32'h12345678);
    check("ovf_set", ovf, 1);
    check("drop1", drop_cnt, 1);
    pop_log.delete();
    drain();
    check("fill_n", pop_log.size(), 8);
    for (int i = 0; i < 8; i++)
      if (i < pop_log.size()) check($sformatf("fill_dat%0d", i), pop_log[i][31:0], 32'h3F800000 + i);
    ovf_clr = 1'b1; cyc(); ovf_clr = 1'b0;

    // Full buffer with a push and a pop in the same cycle
    for (int i = 0; i < 8; i++) push_word(32'h40000000 + i);
    rdy = 1'b1; vin = 1'b1; din = 32'hDEADBEEF; cyc(); vin = 1'b0;
    check("fp_ovf", ovf, 0);
    check("fp_count", count, 8);
    pop_log.delete();
    cyc(8);
    rdy = 1'b0;
    check("fp_n", pop_log.size(), 8);
    if (pop_log.size() == 8) check("fp_last", pop_log[7][31:0], 32'hDEADBEEF);
    for (int i = 0; i < 8; i++) push_word($urandom);
    rdy = 1'b1; vin = 1'b1;
    for (int i = 0; i < 20; i++) begin
      din = $urandom;
      cyc();
    end
    vin = 1'b0;
    check("wrap_ovf", ovf, 0);
    drain();

    // A drop and ovf_clr in the same cycle; then ovf_clr alone; then saturation
    for (int i = 0; i < 8; i++) push_word(32'h3F000000 + i);
    vin = 1'b1; din = 32'h1; ovf_clr = 1'b1; cyc();
    vin = 1'b0;
    check("clr_drop_ovf", ovf, 1);
    check("clr_drop_cnt", drop_cnt, 1);
    cyc(); ovf_clr = 1'b0;
    check("clr_ovf", ovf, 0);
    check("clr_cnt", drop_cnt, 0);
    vin = 1'b1;
    for (int i = 0; i < 300; i++) begin
      din = $urandom;
      cyc();
    end
    vin = 1'b0;
    check("sat_cnt", drop_cnt, 255);
    drain();

    // Reset in the middle of the stream
    for (int i = 0; i < 5; i++) push_word(32'h41000000 + i);
    check("mr_pre_count", count, 5);
    rst = 1'b1; vin = 1'b1; din = 32'hCAFEF00D; cyc();
    rst = 1'b0; vin = 1'b0;
    check("mr_count", count, 0);
    check("mr_vout", vout, 0);
    check("mr_dout", dout, 0);
    check("mr_ovf", ovf, 0);
    push_word(32'h3E800000);
    pop_log.delete();
    drain();
    check("mr_n", pop_log.size(), 1);
    if (pop_log.size() == 1) check("mr_dat", pop_log[0][31:0], 32'h3E800000);

    cyc(2);
    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
